adc_spi_sampler: RTL and testbench

//  SPI master for the GRB Alpha detector ADC (12-bit serial ADC, 16-bit frame, 4 leading zeros).

---
 rtl/grbalpha_pkg.sv | 27 ++
 rtl/spi_sclk_gen.sv | 47 ++++
 rtl/adc_spi_sampler.sv | 141 ++++++++++++++
 tb/tb_adc_spi_sampler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grbalpha_pkg.sv
// Shared constants for the GRB Alpha readout: ADC frame layout and sampler FSM encoding.
// The state encodings are also decoded by the top-level status LEDs.
package grbalpha_pkg;

  localparam int ADC_DATA_BITS  = 12;
  localparam int ADC_FRAME_BITS = 16;
  localparam int ADC_LEAD_BITS  = 4;

  localparam logic [2:0] ADC_ST_IDLE  = 3'd0;
  localparam logic [2:0] ADC_ST_SETUP = 3'd1;
  localparam logic [2:0] ADC_ST_SHIFT = 3'd2;
  localparam logic [2:0] ADC_ST_DONE  = 3'd3;
  localparam logic [2:0] ADC_ST_GAP   = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = ADC_ST_IDLE,
    ST_SETUP = ADC_ST_SETUP,
    ST_SHIFT = ADC_ST_SHIFT,
    ST_DONE  = ADC_ST_DONE,
    ST_GAP   = ADC_ST_GAP
  } adc_state_e;

  function automatic logic lead_bits_clear(input logic [ADC_FRAME_BITS-1:0] frame);
    return frame[ADC_FRAME_BITS-1 -: ADC_LEAD_BITS] == '0;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK generator: CLK_DIV-cycle half periods while RUN_i, idling high; rise/fall strobes
// fire on the cycle before SCLK_o changes, END_o closes the high phase after the 16th rise.
module spi_sclk_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic CLK_i,
  input  logic RST_i,
  input  logic RUN_i,
  output logic SCLK_o,
  output logic RISE_o,
  output logic FALL_o,
  output logic END_o
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic             r_sclk;
  logic [4:0]       r_rises;
  logic             w_tick;
  logic             w_last;

  assign w_tick = RUN_i && (r_cnt == CNT_W'(CLK_DIV - 1));
  assign w_last = (r_rises == 5'd16);

  assign RISE_o = w_tick && !r_sclk;
  assign FALL_o = w_tick && r_sclk && !w_last;
  assign END_o  = w_tick && r_sclk && w_last;
  assign SCLK_o = r_sclk;

  always_ff @(posedge CLK_i) begin
    if (RST_i || !RUN_i) begin
      r_cnt   <= '0;
      r_sclk  <= 1'b1;
      r_rises <= '0;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (RISE_o) begin
        r_sclk  <= 1'b1;
        r_rises <= r_rises + 5'd1;
      end else if (FALL_o) begin
        r_sclk <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/adc_spi_sampler.sv
// SPI master for the 12-bit detector ADC: back-to-back 16-bit frames into a one-entry valid/ready buffer.
// Define ADC_THRESH_EN to silently drop samples below THRESHOLD instead of forwarding them.
module adc_spi_sampler
  import grbalpha_pkg::*;
#(
  parameter int                       CLK_DIV   = 8,
  parameter int                       CONV_GAP  = 16,
  parameter logic [ADC_DATA_BITS-1:0] THRESHOLD = '0
) (
  input  logic                     CLK_i,
  input  logic                     RST_i,
  input  logic                     EN_i,
  output logic                     CS_o,
  output logic                     SCLK_o,
  input  logic                     SDO_i,
  output logic [ADC_DATA_BITS-1:0] SAMPLE_o,
  output logic                     VALID_o,
  input  logic                     READY_i,
  output logic                     OVERRUN_o,
  output logic                     FMT_ERR_o,
  output logic                     BUSY_o
);

  localparam int GAP_W = $clog2(CONV_GAP + 1);

  adc_state_e                r_state;
  logic                      r_cs;
  logic                      r_busy;
  logic                      r_valid;
  logic                      r_overrun;
  logic                      r_fmt_err;
  logic [ADC_DATA_BITS-1:0]  r_sample;
  logic [ADC_FRAME_BITS-1:0] r_shreg;
  logic [GAP_W-1:0]          r_gap_cnt;

  logic                      w_run;
  logic                      w_rise;
  logic                      w_fall;
  logic                      w_end;
  logic                      w_keep;
  logic [ADC_DATA_BITS-1:0]  w_data;

  assign w_run  = (r_state == ST_SETUP) || (r_state == ST_SHIFT);
  assign w_data = r_shreg[ADC_DATA_BITS-1:0];

`ifdef ADC_THRESH_EN
  assign w_keep = (w_data >= THRESHOLD);
`else
  logic w_unused_threshold;
  assign w_unused_threshold = ^THRESHOLD;
  assign w_keep = 1'b1;
`endif

  // SETUP is treated as the first high half-period, so its end is the first SCLK fall.
  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .CLK_i  (CLK_i),
    .RST_i  (RST_i),
    .RUN_i  (w_run),
    .SCLK_o (SCLK_o),
    .RISE_o (w_rise),
    .FALL_o (w_fall),
    .END_o  (w_end)
  );

  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      r_state   <= ST_IDLE;
      r_cs      <= 1'b1;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_fmt_err <= 1'b0;
      r_sample  <= '0;
      r_shreg   <= '0;
      r_gap_cnt <= '0;
    end else begin
      if (r_valid && READY_i) r_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (EN_i) begin
            r_state <= ST_SETUP;
            r_cs    <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (w_fall) r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_rise) r_shreg <= {r_shreg[ADC_FRAME_BITS-2:0], SDO_i};
          if (w_end) begin
            r_state <= ST_DONE;
            r_cs    <= 1'b1;
          end
        end
        ST_DONE: begin
          if (!lead_bits_clear(r_shreg)) r_fmt_err <= 1'b1;
          // A consumer taking the old sample this cycle frees the slot for the new one.
          if (w_keep) begin
            if (!r_valid || READY_i) begin
              r_sample <= w_data;
              r_valid  <= 1'b1;
            end else begin
              r_overrun <= 1'b1;
            end
          end
          r_gap_cnt <= '0;
          r_state   <= ST_GAP;
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_W'(CONV_GAP - 1)) begin
            if (EN_i) begin
              r_state <= ST_SETUP;
              r_cs    <= 1'b0;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cs    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign CS_o      = r_cs;
  assign BUSY_o    = r_busy;
  assign VALID_o   = r_valid;
  assign SAMPLE_o  = r_sample;
  assign OVERRUN_o = r_overrun;
  assign FMT_ERR_o = r_fmt_err;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed bench for adc_spi_sampler with a mode-3 style ADC model that shifts a 16-bit frame out MSB first.
module tb_adc_spi_sampler;

  logic        CLK_i = 1'b0;
  logic        RST_i;
  logic        EN_i;
  logic        SDO_i;
  logic        READY_i;
  logic        CS_o;
  logic        SCLK_o;
  logic        VALID_o;
  logic        OVERRUN_o;
  logic        FMT_ERR_o;
  logic        BUSY_o;
  logic [11:0] SAMPLE_o;

  logic [15:0] adc_frame = 16'h0000;
  int          bit_idx = 0;
  int          checks = 0;
  int          errors = 0;

  adc_spi_sampler #(
    .CLK_DIV   (8),
    .CONV_GAP  (16),
    .THRESHOLD (12'h800)
  ) dut (
    .CLK_i     (CLK_i),
    .RST_i     (RST_i),
    .EN_i      (EN_i),
    .CS_o      (CS_o),
    .SCLK_o    (SCLK_o),
    .SDO_i     (SDO_i),
    .SAMPLE_o  (SAMPLE_o),
    .VALID_o   (VALID_o),
    .READY_i   (READY_i),
    .OVERRUN_o (OVERRUN_o),
    .FMT_ERR_o (FMT_ERR_o),
    .BUSY_o    (BUSY_o)
  );

  initial forever #5 CLK_i = ~CLK_i;

  // ADC model: each SCLK fall presents the next frame bit; CS fall restarts the frame.
  initial begin
    SDO_i = 1'b0;
    forever begin
      @(negedge CS_o or negedge SCLK_o);
      if (CS_o === 1'b0 && SCLK_o === 1'b1) begin
        bit_idx = 0;
      end else if (CS_o === 1'b0 && SCLK_o === 1'b0 && bit_idx < 16) begin
        SDO_i   = adc_frame[15 - bit_idx];
        bit_idx = bit_idx + 1;
      end
    end
  end

  task automatic step();
    @(negedge CLK_i);
  endtask

  // Runs one frame; returns at the first sampled cycle with CS_o high again (the DONE cycle).
  task automatic do_frame(input logic [15:0] f, input logic keep_en,
                          output int low_cyc, output int rises);
    int   n;
    logic prev;
    adc_frame = f;
    EN_i      = 1'b1;
    low_cyc   = 0;
    rises     = 0;
    n         = 0;
    while (CS_o !== 1'b0 && n < 500) begin
      step();
      n++;
    end
    checks++;
    if (CS_o !== 1'b0) begin
      errors++;
      $display("FAIL frame_start: CS_o=%b after %0d cycles, required 0", CS_o, n);
      return;
    end
    EN_i = keep_en;
    prev = SCLK_o;
    while (CS_o === 1'b0 && low_cyc < 1000) begin
      low_cyc++;
      if (prev === 1'b0 && SCLK_o === 1'b1) rises++;
      prev = SCLK_o;
      step();
    end
    checks++;
    if (CS_o !== 1'b1) begin
      errors++;
      $display("FAIL frame_end: CS_o=%b after %0d cycles low, required 1", CS_o, low_cyc);
    end
  endtask

  task automatic test_reset();
    RST_i   = 1'b1;
    EN_i    = 1'b0;
    READY_i = 1'b0;
    step();
    step();
    checks++;
    if ({CS_o, SCLK_o, VALID_o, OVERRUN_o, FMT_ERR_o, BUSY_o} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_flags: {cs,sclk,valid,ovr,fmt,busy}=%b required 110000",
               {CS_o, SCLK_o, VALID_o, OVERRUN_o, FMT_ERR_o, BUSY_o});
    end
    checks++;
    if (SAMPLE_o !== 12'h000) begin
      errors++;
      $display("FAIL reset_sample: SAMPLE_o=%h required 000", SAMPLE_o);
    end
    RST_i = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      checks++;
      if (CS_o !== 1'b1 || SCLK_o !== 1'b1 || BUSY_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold: cycle %0d cs=%b sclk=%b busy=%b required 1 1 0",
                 i, CS_o, SCLK_o, BUSY_o);
      end
    end
  endtask

  task automatic test_single_frame();
    int low_cyc;
    int rises;
    READY_i = 1'b1;
    do_frame(16'h09DB, 1'b0, low_cyc, rises);
    checks++;
    if (low_cyc !== 264) begin
      errors++;
      $display("FAIL cs_low_len: %0d cycles, required 264", low_cyc);
    end
    checks++;
    if (rises !== 16) begin
      errors++;
      $display("FAIL sclk_rises: %0d, required 16", rises);
    end
    checks++;
    if (VALID_o !== 1'b0 || BUSY_o !== 1'b1) begin
      errors++;
      $display("FAIL done_cycle: valid=%b busy=%b required 0 1", VALID_o, BUSY_o);
    end
    step();
    checks++;
    if (VALID_o !== 1'b1 || SAMPLE_o !== 12'h9DB) begin
      errors++;
      $display("FAIL single_sample: valid=%b sample=%h required 1 9db", VALID_o, SAMPLE_o);
    end
    step();
    checks++;
    if (VALID_o !== 1'b0 || SAMPLE_o !== 12'h9DB) begin
      errors++;
      $display("FAIL single_accept: valid=%b sample=%h required 0 9db", VALID_o, SAMPLE_o);
    end
    for (int i = 0; i < 20; i++) step();
    checks++;
    if (BUSY_o !== 1'b0 || CS_o !== 1'b1) begin
      errors++;
      $display("FAIL back_to_idle: busy=%b cs=%b required 0 1", BUSY_o, CS_o);
    end
  endtask

  task automatic test_overrun();
    int low_cyc;
    int rises;
    READY_i = 1'b0;
    do_frame(16'h09DB, 1'b0, low_cyc, rises);
    step();
    checks++;
    if (VALID_o !== 1'b1 || SAMPLE_o !== 12'h9DB || OVERRUN_o !== 1'b0) begin
      errors++;
      $display("FAIL ovr_frame1: valid=%b sample=%h ovr=%b required 1 9db 0",
               VALID_o, SAMPLE_o, OVERRUN_o);
    end
    do_frame(16'h0123, 1'b0, low_cyc, rises);
    step();
    checks++;
    if (VALID_o !== 1'b1 || SAMPLE_o !== 12'h9DB || OVERRUN_o !== 1'b1) begin
      errors++;
      $display("FAIL ovr_frame2: valid=%b sample=%h ovr=%b required 1 9db 1",
               VALID_o, SAMPLE_o, OVERRUN_o);
    end
    READY_i = 1'b1;
    step();
    checks++;
    if (VALID_o !== 1'b0 || OVERRUN_o !== 1'b1) begin
      errors++;
      $display("FAIL ovr_drain: valid=%b ovr=%b required 0 1", VALID_o, OVERRUN_o);
    end
  endtask

  task automatic test_fmt_err();
    int low_cyc;
    int rises;
    READY_i = 1'b0;
    checks++;
    if (FMT_ERR_o !== 1'b0) begin
      errors++;
      $display("FAIL fmt_before: FMT_ERR_o=%b required 0", FMT_ERR_o);
    end
    do_frame(16'hF123, 1'b0, low_cyc, rises);
    step();
    checks++;
    if (FMT_ERR_o !== 1'b1 || SAMPLE_o !== 12'h123 || VALID_o !== 1'b1 || OVERRUN_o !== 1'b1) begin
      errors++;
      $display("FAIL fmt_frame: fmt=%b sample=%h valid=%b ovr=%b required 1 123 1 1",
               FMT_ERR_o, SAMPLE_o, VALID_o, OVERRUN_o);
    end
    READY_i = 1'b1;
    step();
    checks++;
    if (VALID_o !== 1'b0 || FMT_ERR_o !== 1'b1) begin
      errors++;
      $display("FAIL fmt_sticky: valid=%b fmt=%b required 0 1", VALID_o, FMT_ERR_o);
    end
  endtask

  task automatic test_reset_mid_frame();
    int   n;
    int   rises;
    int   low_cyc;
    int   valid_seen;
    logic prev;
    READY_i   = 1'b1;
    adc_frame = 16'h0555;
    EN_i      = 1'b1;
    n         = 0;
    rises     = 0;
    while (CS_o !== 1'b0 && n < 500) begin
      step();
      n++;
    end
    prev = SCLK_o;
    while (rises < 7 && n < 1000) begin
      step();
      n++;
      if (prev === 1'b0 && SCLK_o === 1'b1) rises++;
      prev = SCLK_o;
    end
    checks++;
    if (rises !== 7) begin
      errors++;
      $display("FAIL mid_reach_bit7: rises=%0d required 7", rises);
    end
    EN_i  = 1'b0;
    RST_i = 1'b1;
    step();
    checks++;
    if ({CS_o, SCLK_o, VALID_o, OVERRUN_o, FMT_ERR_o, BUSY_o} !== 6'b110000 || SAMPLE_o !== 12'h000) begin
      errors++;
      $display("FAIL mid_reset: {cs,sclk,valid,ovr,fmt,busy}=%b sample=%h required 110000 000",
               {CS_o, SCLK_o, VALID_o, OVERRUN_o, FMT_ERR_o, BUSY_o}, SAMPLE_o);
    end
    RST_i      = 1'b0;
    valid_seen = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (VALID_o !== 1'b0) valid_seen++;
    end
    checks++;
    if (valid_seen !== 0) begin
      errors++;
      $display("FAIL mid_no_valid: VALID_o high %0d cycles, required 0", valid_seen);
    end
    do_frame(16'h0ABC, 1'b0, low_cyc, rises);
    checks++;
    if (low_cyc !== 264 || rises !== 16) begin
      errors++;
      $display("FAIL post_reset_frame: low=%0d rises=%0d required 264 16", low_cyc, rises);
    end
    step();
    checks++;
    if (VALID_o !== 1'b1 || SAMPLE_o !== 12'hABC) begin
      errors++;
      $display("FAIL post_reset_sample: valid=%b sample=%h required 1 abc", VALID_o, SAMPLE_o);
    end
    for (int i = 0; i < 20; i++) step();
  endtask

`ifdef ADC_THRESH_EN
  task automatic test_threshold();
    int low_cyc;
    int rises;
    RST_i   = 1'b1;
    READY_i = 1'b0;
    EN_i    = 1'b0;
    step();
    step();
    RST_i = 1'b0;
    do_frame(16'h07FF, 1'b0, low_cyc, rises);
    step();
    checks++;
    if (VALID_o !== 1'b0 || SAMPLE_o !== 12'h000) begin
      errors++;
      $display("FAIL thresh_below: valid=%b sample=%h required 0 000", VALID_o, SAMPLE_o);
    end
    do_frame(16'h0800, 1'b0, low_cyc, rises);
    step();
    checks++;
    if (VALID_o !== 1'b1 || SAMPLE_o !== 12'h800 || OVERRUN_o !== 1'b0) begin
      errors++;
      $display("FAIL thresh_at: valid=%b sample=%h ovr=%b required 1 800 0",
               VALID_o, SAMPLE_o, OVERRUN_o);
    end
  endtask
`endif

  initial begin
    RST_i   = 1'b1;
    EN_i    = 1'b0;
    READY_i = 1'b0;
    test_reset();
    test_single_frame();
    test_overrun();
    test_fmt_err();
    test_reset_mid_frame();
`ifdef ADC_THRESH_EN
    test_threshold();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
